// File: rtl/rob_pkg.sv
// rob_pkg: shared sizes, tag/register sentinels, instruction types and FSM states for the reorder buffer.
package rob_pkg;
  localparam int DEPTH = 16;
  localparam int TAG_W = 5;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] ENTRY_NULL = TAG_W'(DEPTH);
  localparam logic [5:0] REG_NULL = 6'd32;
  localparam logic [1:0] TYPE_ALU = 2'd0;
  localparam logic [1:0] TYPE_BR = 2'd1;
  localparam logic [1:0] TYPE_ST = 2'd2;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;
  function automatic logic tag_ok(input logic [TAG_W-1:0] t);
    return t < TAG_W'(DEPTH);
  endfunction
endpackage

// File: rtl/rob.sv
// rob: reorder buffer; in-order tag allocation, CDB writeback, in-order retire and mispredict rollback.
module rob
  import rob_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             issue_sgn,
  input  logic [5:0]       issue_rd,
  input  logic [1:0]       issue_type,
  input  logic [31:0]      issue_pc,
  input  logic             issue_pred_taken,
  output logic [TAG_W-1:0] rob_new_entry,
  output logic             rob_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_entry,
  input  logic [31:0]      cdb_result,
  input  logic             cdb_taken,
  input  logic [31:0]      cdb_target,
  input  logic [TAG_W-1:0] qry1_entry,
  input  logic [TAG_W-1:0] qry2_entry,
  output logic             qry1_ready,
  output logic             qry2_ready,
  output logic [31:0]      qry1_value,
  output logic [31:0]      qry2_value,
  output logic             commit_sgn,
  output logic [TAG_W-1:0] rob_entry,
  output logic [5:0]       rob_des,
  output logic [31:0]      rob_result,
  output logic             store_commit_sgn,
  output logic             rollback,
  output logic [31:0]      rollback_pc
);
  logic [DEPTH-1:0] busy, done, busy_n, done_n, pred, taken;
  logic [1:0] typ [DEPTH];
  logic [5:0] rd [DEPTH];
  logic [31:0] pc [DEPTH], target [DEPTH], result [DEPTH];
  logic [PTR_W-1:0] head, tail, ci, q1, q2;
  logic [TAG_W-1:0] count;
  state_t state;
  logic issue_ok, cdb_ok, do_commit, mis, fwd1, fwd2;
  assign ci = cdb_entry[PTR_W-1:0];
  assign q1 = qry1_entry[PTR_W-1:0];
  assign q2 = qry2_entry[PTR_W-1:0];
  assign rob_full = count == TAG_W'(DEPTH) || state != RUN;
  assign rob_new_entry = TAG_W'(tail);
  assign issue_ok = issue_sgn && !rob_full;
  assign cdb_ok = cdb_valid && state != RECOVER && tag_ok(cdb_entry) && busy[ci];
  assign do_commit = state == RUN && busy[head] && done[head];
  assign mis = typ[head] == TYPE_BR && taken[head] != pred[head];
  assign fwd1 = cdb_valid && state != RECOVER && cdb_entry == qry1_entry;
  assign fwd2 = cdb_valid && state != RECOVER && cdb_entry == qry2_entry;
  assign qry1_ready = tag_ok(qry1_entry) && (done[q1] || fwd1);
  assign qry2_ready = tag_ok(qry2_entry) && (done[q2] || fwd2);
  assign qry1_value = !tag_ok(qry1_entry) ? 32'd0 : done[q1] ? result[q1] : fwd1 ? cdb_result : 32'd0;
  assign qry2_value = !tag_ok(qry2_entry) ? 32'd0 : done[q2] ? result[q2] : fwd2 ? cdb_result : 32'd0;
  always_comb begin
    busy_n = busy;
    done_n = done;
    if (issue_ok) begin
      busy_n[tail] = TRUE;
      done_n[tail] = FALSE;
    end
    if (do_commit) begin
      busy_n[head] = FALSE;
      done_n[head] = FALSE;
    end
    if (cdb_ok) done_n[ci] = TRUE;
    if (state == FLUSH) begin
      busy_n = '0;
      done_n = '0;
    end
  end
  // Commit of a mispredicted branch enters FLUSH; the flush itself happens one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      state <= RUN;
      commit_sgn <= FALSE;
      store_commit_sgn <= FALSE;
      rollback <= FALSE;
      rollback_pc <= '0;
      rob_entry <= ENTRY_NULL;
      rob_des <= REG_NULL;
      rob_result <= '0;
    end else if (rdy) begin
      busy <= busy_n;
      done <= done_n;
      commit_sgn <= do_commit;
      store_commit_sgn <= do_commit && typ[head] == TYPE_ST;
      rollback <= state == FLUSH;
      if (do_commit) begin
        rob_entry <= TAG_W'(head);
        rob_des <= typ[head] == TYPE_ST ? REG_NULL : rd[head];
        rob_result <= result[head];
      end
      if (state == FLUSH) begin
        head <= '0;
        tail <= '0;
        count <= '0;
        state <= RECOVER;
      end else begin
        head <= head + PTR_W'(do_commit);
        tail <= tail + PTR_W'(issue_ok);
        count <= count + TAG_W'(issue_ok) - TAG_W'(do_commit);
        state <= do_commit && mis ? FLUSH : RUN;
        if (do_commit && mis) rollback_pc <= taken[head] ? target[head] : pc[head] + 32'd4;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rdy) begin
      if (issue_ok) begin
        typ[tail] <= issue_type;
        rd[tail] <= issue_rd;
        pc[tail] <= issue_pc;
        pred[tail] <= issue_pred_taken;
      end
      if (cdb_ok) begin
        result[ci] <= cdb_result;
        taken[ci] <= cdb_taken;
        target[ci] <= cdb_target;
      end
    end
  end
endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer for the Tomasulo core.
- Allocates in-order tags at issue and collects results from the CDB.
- Retires one instruction per cycle in program order on the commit interface that the regfile consumes (commit_sgn/rob_entry/rob_des/rob_result).
- On branch mispredict, drives the global rollback that flushes regfile, RS and LSB.

Parameters:
- DEPTH, 16, number of entries (power of two).
- TAG_W, 5, tag width; tags 0..DEPTH-1 are valid, ENTRY_NULL = DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global pause; when low, all state and outputs hold.
- issue_sgn  in  1  allocate an entry this cycle.
- issue_rd  in  6  destination register; REG_NULL (6'd32) = none.
- issue_type  in  2  0 ALU/load, 1 branch/jump, 2 store.
- issue_pc  in  32  instruction PC.
- issue_pred_taken  in  1  predicted direction.
- rob_new_entry  out  TAG_W  tag given to the issuing instruction (= tail).
- rob_full  out  1  no free entry.
- cdb_valid  in  1  result broadcast.
- cdb_entry  in  TAG_W  tag of result.
- cdb_result  in  32  value (link address for jumps).
- cdb_taken  in  1  actual branch direction.
- cdb_target  in  32  actual taken target.
- qry1_entry, qry2_entry  in  TAG_W  operand tags from RS.
- qry1_ready, qry2_ready  out  1  tag has a result.
- qry1_value, qry2_value  out  32  that result.
- commit_sgn  out  1  retire pulse.
- rob_entry  out  TAG_W  retired tag.
- rob_des  out  6  retired rd, or REG_NULL.
- rob_result  out  32  retired value.
- store_commit_sgn  out  1  head store may write memory.
- rollback  out  1  flush pulse.
- rollback_pc  out  32  refetch PC.

Behaviour:
- Storage per entry: busy, ready, type, rd, pc, pred, taken, target, result. Head and tail pointers wrap modulo DEPTH; count has range 0..DEPTH.
- Reset (rst low, asynchronous):
  - all busy/ready cleared; head=tail=count=0; state RUN;
  - commit_sgn=0, store_commit_sgn=0, rollback=0, rollback_pc=0, rob_entry=ENTRY_NULL, rob_des=REG_NULL, rob_result=0.
- Combinational outputs:
  - rob_new_entry = tail.
  - rob_full = (count==DEPTH) or state!=RUN.
- Issue: when issue_sgn && !rob_full && state==RUN, write the entry at tail (busy=1, ready=0) and increment tail.
- Writeback: when cdb_valid and entry cdb_entry is busy, set ready and latch result/taken/target. A cdb for a non-busy tag is ignored.
- Query: qryN_ready = 1 when either holds:
  - the entry is ready; or
  - cdb_valid and cdb_entry==qryN_entry (same-cycle forward, value taken from cdb_result).
  - ENTRY_NULL returns ready=0, value=0.
- Commit (RUN only): when the head is busy && ready, register at the next edge:
  - commit_sgn=1, rob_entry=head, rob_des=rd, rob_result=result;
  - store_commit_sgn=1 if type==store, with rob_des forced to REG_NULL;
  - clear busy and advance head.
- All pulse outputs are single-cycle; they default to 0 when nothing retires.
- count' = count + issue_accept - commit. Issue and commit in the same cycle leave count unchanged. rob_full is evaluated on the pre-edge count, so a commit does not free a slot for a same-cycle issue.
- Mispredict: the head is a branch whose taken != pred.
  - Edge E: commit as normal; rollback_pc = taken ? target : pc+4; state <= FLUSH.
  - Edge E+1: rollback=1; all busy cleared; head=tail=count=0; state <= RECOVER.
  - Edge E+2: rollback=0; state <= RUN.
  - Issue is refused during FLUSH and RECOVER; cdb is ignored during RECOVER.
- rdy=0 freezes everything, including held pulses, so downstream consumers that also freeze see each pulse exactly once.
- Reset mid-FLUSH aborts immediately; rollback is never asserted.

Decomposition:
- Shared defines: DEPTH, TAG_W, ENTRY_NULL, REG_NULL, issue_type encodings (TYPE_ALU, TYPE_BR, TYPE_ST), TRUE/FALSE.
- Single module. Entry storage is plain arrays; no sub-module is warranted.

Test Plan:
- Issue 3 ALU ops (rd=1,2,3) → tags 0,1,2. CDB tags in order 2,0,1 with values 30,10,20 → commits in order tag0/rd1/10, tag1/rd2/20, tag2/rd3/30, one per cycle.
- Issue 16 with no CDB → rob_full=1 after the 16th, and a 17th issue is ignored. Then CDB tag0 → commit occurs, and the issue in that same cycle is still refused; the next cycle it is accepted with tag 0 (wrap-around).
- Branch at pc=0x100 with pred=0, CDB taken=1, target=0x200, plus a younger ALU behind it → branch commits, rollback pulses the next cycle with rollback_pc=0x200, then count=0 and the next issue gets tag 0. Repeat with pred=1, taken=0 → rollback_pc=0x104.
- cdb_valid tag 5 value 0xDEAD while qry1_entry=5 in the same cycle → qry1_ready=1, qry1_value=0xDEAD combinationally.
- Store at head → store_commit_sgn=1 with rob_des=REG_NULL. Hold rdy=0 for 3 cycles during the commit pulse → the pulse is held and retires exactly once after rdy rises.
- Drive rst low during FLUSH → all outputs reach their reset values asynchronously, and rollback never pulses.
